// File: rtl/axis_video_pkg.sv
// axis_video_pkg: shared encodings for the AXI4-Stream video test-pattern
// generator.
//   pat_e         pattern-select encodings carried on pattern_sel
//   state_e       frame sequencer states
//   BAR_*         the eight colour-bar colours, left to right
//   bar_colour()  maps a bar index (0..7) onto its colour
package axis_video_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tpg_pixel_gen.sv
// tpg_pixel_gen: purely combinational pixel colour for one raster position.
//   pattern_i  latched pattern select
//   x_i, y_i   pixel coordinates
//   bar_i      colour-bar index of x_i (kept by the caller's sub-counter)
//   solid_i    latched solid colour
//   rgb_o      {R, G, B} for this pixel
module tpg_pixel_gen
  import axis_video_pkg::*;
#(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
) (
  input  pat_e              pattern_i,
  input  logic [XW-1:0]     x_i,
  input  logic [YW-1:0]     y_i,
  input  logic [2:0]        bar_i,
  input  logic [23:0]       solid_i,
  output logic [23:0]       rgb_o
);

  logic [7:0] ramp_s;
  logic       chk_s;

  // Pattern selection; the checker bit is x[5] ^ y[5], i.e. 32x32 squares.
  always_comb begin
    ramp_s = 8'(x_i);
    chk_s  = 1'((16'(x_i) ^ 16'(y_i)) >> 4'd5);
    case (pattern_i)
      PAT_BARS:  rgb_o = bar_colour(bar_i);
      PAT_RAMP:  rgb_o = {ramp_s, ramp_s, ramp_s};
      PAT_CHECK: rgb_o = chk_s ? BAR_WHITE : BAR_BLACK;
      PAT_SOLID: rgb_o = solid_i;
      default:   rgb_o = BAR_BLACK;
    endcase
  end

endmodule

// File: rtl/axis_video_tpg.sv
// axis_video_tpg: AXI4-Stream video test-pattern generator.
// Emits raster frames of H_ACTIVE x V_ACTIVE RGB pixels with tuser on (0,0)
// and tlast on each line end, honouring backpressure, with FRAME_GAP idle
// cycles between frames.
//   aclk, aresetn   clock and synchronous active-low reset
//   enable          run request, sampled only at frame boundaries
//   pattern_sel     0 bars, 1 ramp, 2 checkerboard, 3 solid (latched per frame)
//   solid_rgb       colour for the solid pattern (latched per frame)
//   m_axis_*        AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   frame_done      one-cycle pulse after the last pixel of a frame is accepted
//   frame_count     completed-frame counter, wraps at 0xFFFF
module axis_video_tpg
  import axis_video_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned FRAME_GAP  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [23:0]           solid_rgb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int unsigned XW  = $clog2(H_ACTIVE);
  localparam int unsigned YW  = (V_ACTIVE > 32'd1) ? $clog2(V_ACTIVE) : 32'd1;
  localparam int unsigned BW  = H_ACTIVE / 32'd8;
  localparam int unsigned BCW = (BW > 32'd1) ? $clog2(BW) : 32'd1;
  localparam int unsigned GW  = (FRAME_GAP > 32'd1) ? $clog2(FRAME_GAP) : 32'd1;

  localparam logic [XW-1:0]  X_LAST   = XW'(H_ACTIVE - 32'd1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(V_ACTIVE - 32'd1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(BW - 32'd1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((FRAME_GAP > 32'd0) ? FRAME_GAP - 32'd1 : 32'd0);
  localparam bit             NO_GAP   = (FRAME_GAP == 32'd0);

  state_e                state_q;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [2:0]            bar_q, bar_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  pat_e                  pat_q, pat_d;
  logic [23:0]           solid_q, solid_d;
  logic [GW-1:0]         gap_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tuser_q;
  logic                  done_q;
  logic [15:0]           frame_count_q;
  logic [23:0]           rgb_s;

  logic hs_s, last_s, gap_exp_s, start_s, load_s, adv_s;

  assign hs_s      = tvalid_q & m_axis_tready;
  assign last_s    = (x_q == X_LAST) && (y_q == Y_LAST);
  assign gap_exp_s = (state_q == GAP) && (gap_q == GAP_LAST);
  // A frame starts from IDLE, at gap expiry, or straight after the last
  // pixel when there is no inter-frame gap.
  assign start_s   = enable && ((state_q == IDLE) || gap_exp_s ||
                     ((state_q == ACTIVE) && hs_s && last_s && NO_GAP));
  assign load_s    = start_s || ((state_q == ACTIVE) && hs_s && !last_s);
  assign adv_s     = load_s || ((state_q == ACTIVE) && hs_s && last_s);
  assign tvalid_d  = load_s || (tvalid_q && !hs_s);

  // Coordinates of the pixel to present next: frame origin on a start,
  // otherwise the raster successor of the pixel just accepted.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    bar_d   = bar_q;
    bcnt_d  = bcnt_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    if (start_s) begin
      x_d     = '0;
      y_d     = '0;
      bar_d   = 3'd0;
      bcnt_d  = '0;
      pat_d   = pat_e'(pattern_sel);
      solid_d = solid_rgb;
    end else if (x_q == X_LAST) begin
      x_d    = '0;
      bar_d  = 3'd0;
      bcnt_d = '0;
      if (y_q == Y_LAST) begin
        y_d = '0;
      end else begin
        y_d = y_q + YW'(1);
      end
    end else begin
      x_d = x_q + XW'(1);
      if (bcnt_q == BC_LAST) begin
        bcnt_d = '0;
        bar_d  = bar_q + 3'd1;
      end else begin
        bcnt_d = bcnt_q + BCW'(1);
      end
    end
  end

  tpg_pixel_gen #(
    .XW (XW),
    .YW (YW)
  ) u_pixel_gen (
    .pattern_i (pat_d),
    .x_i       (x_d),
    .y_i       (y_d),
    .bar_i     (bar_d),
    .solid_i   (solid_d),
    .rgb_o     (rgb_s)
  );

  // Frame sequencer with raster counters, pattern latch and output register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      bar_q         <= 3'd0;
      bcnt_q        <= '0;
      pat_q         <= PAT_BARS;
      solid_q       <= 24'h000000;
      gap_q         <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      done_q   <= 1'b0;
      tvalid_q <= tvalid_d;
      if (adv_s) begin
        x_q     <= x_d;
        y_q     <= y_d;
        bar_q   <= bar_d;
        bcnt_q  <= bcnt_d;
        pat_q   <= pat_d;
        solid_q <= solid_d;
      end
      // The held beat only changes when a new pixel is loaded.
      if (load_s) begin
        tdata_q <= DATA_WIDTH'(rgb_s);
        tlast_q <= (x_d == X_LAST);
        tuser_q <= (x_d == '0) && (y_d == '0);
      end else if (!tvalid_d) begin
        tlast_q <= 1'b0;
        tuser_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_s) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (hs_s && last_s) begin
            done_q        <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            gap_q         <= '0;
            if (!start_s) state_q <= NO_GAP ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_exp_s) begin
            gap_q   <= '0;
            state_q <= start_s ? ACTIVE : IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_done    = done_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axis_video_tpg.sv
// tb_axis_video_tpg: directed/randomised bench for axis_video_tpg using a
// 16x4 raster with a 3-cycle frame gap. Expected pixels come from a
// coordinate-based colour model; frame_count is tracked independently.
module tb_axis_video_tpg;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int G  = 3;
  localparam int FB = H * V;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        frame_done;
  logic [15:0] frame_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_fc   = 16'h0000;

  axis_video_tpg #(
    .DATA_WIDTH (24),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FRAME_GAP  (G)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .pattern_sel   (pattern_sel),
    .solid_rgb     (solid_rgb),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_done    (frame_done),
    .frame_count   (frame_count)
  );

  always #5 aclk = ~aclk;

  // Colour of pixel (x, y) derived directly from the pattern definitions.
  function automatic logic [23:0] model_pix(input int pat, input logic [23:0] solid,
                                            input int x, input int y);
    int r;
    case (pat)
      0: return BARS[x / (H / 8)];
      1: begin r = x % 256; return {r[7:0], r[7:0], r[7:0]}; end
      2: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Streams one frame; act: 0 none, 1 drop enable, 2 switch to solid 123456,
  // 3 assert reset. The action fires once when act_beat beats have been taken.
  task automatic stream_frame(input int pat, input logic [23:0] solid, input int pct,
                              input int act_beat, input int act, input string tag,
                              output bit aborted);
    int beat, cycles, bubbles, x, y;
    bit stalled, act_done;
    logic [23:0] hd;
    logic hl, hu;
    beat = 0; cycles = 0; bubbles = 0; stalled = 0; act_done = 0; aborted = 0;
    hd = '0; hl = 1'b0; hu = 1'b0;
    while (beat < FB && cycles < 1000 && !aborted) begin
      if (stalled) begin
        check({tag, "_hold_valid"}, m_axis_tvalid, 1);
        check({tag, "_hold_data"}, m_axis_tdata, hd);
        check({tag, "_hold_last"}, m_axis_tlast, hl);
        check({tag, "_hold_user"}, m_axis_tuser, hu);
      end
      check({tag, "_no_done"}, frame_done, 0);
      if (beat == act_beat && !act_done) begin
        act_done = 1;
        case (act)
          1: enable = 1'b0;
          2: begin pattern_sel = 2'd3; solid_rgb = 24'h123456; end
          3: begin
            aresetn = 1'b0;
            tick();
            check({tag, "_rst_valid"}, m_axis_tvalid, 0);
            check({tag, "_rst_data"}, m_axis_tdata, 0);
            check({tag, "_rst_last"}, m_axis_tlast, 0);
            check({tag, "_rst_user"}, m_axis_tuser, 0);
            check({tag, "_rst_done"}, frame_done, 0);
            check({tag, "_rst_fc"}, frame_count, 0);
            exp_fc  = 16'h0000;
            aresetn = 1'b1;
            aborted = 1;
          end
          default: ;
        endcase
      end
      if (!aborted) begin
        m_axis_tready = ($urandom_range(99) < pct);
        if (!m_axis_tvalid) bubbles++;
        stalled = m_axis_tvalid && !m_axis_tready;
        hd = m_axis_tdata; hl = m_axis_tlast; hu = m_axis_tuser;
        if (m_axis_tvalid && m_axis_tready) begin
          x = beat % H;
          y = beat / H;
          check($sformatf("%s_data_b%0d", tag, beat), m_axis_tdata, model_pix(pat, solid, x, y));
          check($sformatf("%s_last_b%0d", tag, beat), m_axis_tlast, (x == H - 1));
          check($sformatf("%s_user_b%0d", tag, beat), m_axis_tuser, (x == 0 && y == 0));
          beat++;
        end
        tick();
        cycles++;
      end
    end
    if (!aborted) begin
      check({tag, "_beats"}, beat, FB);
      check({tag, "_bubbles"}, bubbles, 0);
      exp_fc = exp_fc + 16'd1;
      check({tag, "_done"}, frame_done, 1);
      check({tag, "_fc"}, frame_count, exp_fc);
    end
  endtask

  // Observes the inter-frame gap starting in the cycle after frame_done.
  task automatic gap_check(input bit expect_next, input string tag);
    for (int i = 0; i < G; i++) begin
      check({tag, "_gap_valid"}, m_axis_tvalid, 0);
      if (i > 0) check({tag, "_gap_done"}, frame_done, 0);
      tick();
    end
    check({tag, "_next_valid"}, m_axis_tvalid, expect_next);
    if (expect_next) check({tag, "_next_user"}, m_axis_tuser, 1);
  endtask

  initial begin
    bit ab;
    aresetn = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 24'h0;
    m_axis_tready = 1'b0;
    repeat (3) tick();
    check("reset_valid", m_axis_tvalid, 0);
    check("reset_data", m_axis_tdata, 0);
    check("reset_last", m_axis_tlast, 0);
    check("reset_user", m_axis_tuser, 0);
    check("reset_done", frame_done, 0);
    check("reset_fc", frame_count, 0);
    aresetn = 1'b1;
    tick();
    check("idle_valid", m_axis_tvalid, 0);

    // Colour bars, continuous tready; pixel (0,0) one cycle after enable.
    enable = 1'b1;
    tick();
    check("start_valid", m_axis_tvalid, 1);
    check("start_user", m_axis_tuser, 1);
    check("bar_x0", m_axis_tdata, 24'hFFFFFF);
    stream_frame(0, 24'h0, 100, -1, 0, "bars", ab);

    // Ramp under 50% random backpressure.
    pattern_sel = 2'd1;
    gap_check(1, "bars");
    stream_frame(1, 24'h0, 50, -1, 0, "ramp", ab);

    // Checkerboard; pattern inputs change mid-frame but must not take effect.
    pattern_sel = 2'd2;
    gap_check(1, "ramp");
    stream_frame(2, 24'h0, 70, 10, 2, "check", ab);

    // Solid frame latched from the mid-frame change; enable dropped at pixel 20.
    gap_check(1, "check");
    stream_frame(3, 24'h123456, 60, 20, 1, "solid", ab);
    gap_check(0, "solid");
    for (int i = 0; i < 8; i++) begin
      check("idle_hold_valid", m_axis_tvalid, 0);
      check("idle_hold_done", frame_done, 0);
      tick();
    end

    // frame_count wrap from FFFF.
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tick();
    check("fc_forced", frame_count, 16'hFFFF);
    exp_fc = 16'hFFFF;
    pattern_sel = 2'd1;
    enable = 1'b1;
    tick();
    check("wrap_start_valid", m_axis_tvalid, 1);
    stream_frame(1, 24'h0, 50, -1, 0, "wrap", ab);
    check("fc_wrapped", frame_count, 16'h0000);

    // Reset at beat 30, then restart from (0,0).
    pattern_sel = 2'd0;
    gap_check(1, "wrap");
    stream_frame(0, 24'h0, 50, 30, 3, "rst", ab);
    check("rst_aborted", ab, 1);
    tick();
    check("rst_restart_valid", m_axis_tvalid, 1);
    check("rst_restart_user", m_axis_tuser, 1);
    check("rst_restart_data", m_axis_tdata, model_pix(0, 24'h0, 0, 0));
    check("rst_restart_fc", frame_count, 0);
    stream_frame(0, 24'h0, 50, -1, 0, "post_rst", ab);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
